// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port, synchronous-read data RAM between the
// instruction fetch (word reads) and load/store (byte/half/word) requesters.
// Grants and RAM drive are combinational; read ownership is tracked for the
// one-cycle RAM latency and LS load data is extracted and extended on return.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store port
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_mode,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  // RAM port
  output logic              ram_we,
  output logic [1:0]        ram_mode,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  logic [CNT_W-1:0] starve_cnt;
  logic             if_force;
  logic             ls_bad;

  // registered issue-cycle attributes of the LS load in flight
  logic [1:0]       off_q;
  logic [1:0]       mode_q;
  logic             uns_q;

  // Misaligned or illegal LS accesses never reach the RAM
  always_comb begin
    ls_bad = 1'b0;
    case (ls_mode)
      MODE_BYTE: ls_bad = 1'b0;
      MODE_HALF: ls_bad = ls_addr[0];
      MODE_WORD: ls_bad = (ls_addr[1:0] != 2'b00);
      default:   ls_bad = 1'b1;
    endcase
  end

  // Arbitration: LS has priority unless IF has waited STARVE_MAX cycles
  always_comb begin
    if_force = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
    ls_gnt   = ls_req && !if_force;
    if_gnt   = if_req && !ls_gnt;
  end

  // RAM drive for the issuing requester; idle pattern otherwise
  always_comb begin
    ram_we    = 1'b0;
    ram_mode  = MODE_WORD;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    if (if_gnt) begin
      ram_addr = 32'(if_addr);
    end else if (ls_gnt && !ls_bad) begin
      ram_we    = ls_we;
      ram_mode  = ls_mode;
      ram_addr  = 32'(ls_addr);
      ram_wdata = ls_wdata;
    end
  end

  // Starvation counter: counts consecutive IF waiting cycles, saturating
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Read ownership, error pulse and LS extraction attributes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      off_q     <= 2'b00;
      mode_q    <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_gnt && !ls_bad && !ls_we;
      ls_err    <= ls_gnt && ls_bad;
      if (ls_gnt) begin
        off_q  <= ls_addr[1:0];
        mode_q <= ls_mode;
        uns_q  <= ls_unsigned;
      end
    end
  end

  // IF data is the raw RAM word
  assign if_rdata = ram_rdata;

  // LS load lane extraction and sign/zero extension
  always_comb begin
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    byte_lane = 8'(ram_rdata >> {off_q, 3'b000});
    half_lane = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (mode_q)
      MODE_BYTE: ls_rdata = {{24{!uns_q && byte_lane[7]}}, byte_lane};
      MODE_HALF: ls_rdata = {{16{!uns_q && half_lane[15]}}, half_lane};
      default:   ls_rdata = ram_rdata;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous-read RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_unsigned;
  logic [1:0]  ls_mode;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        ram_we;
  logic [1:0]  ram_mode;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];

  mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_mode(ls_mode),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_we(ram_we), .ram_mode(ram_mode), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: byte-lane writes, registered word reads
  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_mode)
        2'b00:   mem[ram_addr[7:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[7:0];
        2'b01:   mem[ram_addr[7:2]][16*ram_addr[1] +: 16] <= ram_wdata[15:0];
        default: mem[ram_addr[7:2]] <= ram_wdata;
      endcase
    end else begin
      ram_rdata <= mem[ram_addr[7:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_mode = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    #3;
    tests++; if (if_rvalid !== 1'b0) begin fails++; $display("FAIL reset_if_rvalid got %b want 0", if_rvalid); end
    tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL reset_ls_rvalid got %b want 0", ls_rvalid); end
    tests++; if (ls_err !== 1'b0) begin fails++; $display("FAIL reset_ls_err got %b want 0", ls_err); end
    tests++; if (dut.starve_cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", dut.starve_cnt); end
    tests++; if ({if_gnt, ls_gnt, ram_we, ram_mode, ram_addr} !== {3'b000, 2'b10, 32'h0}) begin
      fails++; $display("FAIL reset_idle_drive got gnt=%b%b we=%b mode=%b addr=%h want 00 0 10 0", if_gnt, ls_gnt, ram_we, ram_mode, ram_addr);
    end
    step(); step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    tests++; if ({if_gnt, ls_gnt, ram_we, ram_mode, ram_addr} !== {3'b100, 2'b10, 32'h10}) begin
      fails++; $display("FAIL if_issue got gnt=%b%b we=%b mode=%b addr=%h want 10 0 10 10", if_gnt, ls_gnt, ram_we, ram_mode, ram_addr);
    end
    step();
    if_req = 1'b0;
    tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL if_rdata got v=%b d=%h want 1 deadbeef", if_rvalid, if_rdata);
    end
    step();
    tests++; if (if_rvalid !== 1'b0) begin fails++; $display("FAIL if_rvalid_once got %b want 0", if_rvalid); end
  endtask

  task automatic test_ls_loads();
    logic [31:0] addrs [3] = '{32'h21, 32'h21, 32'h22};
    logic [1:0]  modes [3] = '{2'b00, 2'b00, 2'b01};
    logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [3] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8086};
    for (int i = 0; i < 3; i++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = addrs[i]; ls_mode = modes[i]; ls_unsigned = unss[i];
      #1;
      tests++; if (ls_gnt !== 1'b1 || ram_mode !== modes[i]) begin
        fails++; $display("FAIL ls_load_issue[%0d] got gnt=%b mode=%b want 1 %b", i, ls_gnt, ram_mode, modes[i]);
      end
      step();
      ls_req = 1'b0;
      tests++; if (ls_rvalid !== 1'b1 || ls_rdata !== exps[i]) begin
        fails++; $display("FAIL ls_load[%0d] got v=%b d=%h want 1 %h", i, ls_rvalid, ls_rdata, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    ls_req = 1'b1; ls_we = 1'b1; ls_mode = 2'b00; ls_addr = 32'h33; ls_wdata = 32'h000000AB;
    #1;
    tests++; if ({ls_gnt, ram_we, ram_mode, ram_addr} !== {2'b11, 2'b00, 32'h33}) begin
      fails++; $display("FAIL sb_issue got gnt=%b we=%b mode=%b addr=%h want 1 1 00 33", ls_gnt, ram_we, ram_mode, ram_addr);
    end
    step();
    ls_we = 1'b0; ls_mode = 2'b10; ls_addr = 32'h30; ls_wdata = 32'h0;
    #1;
    tests++; if (ls_gnt !== 1'b1 || ls_rvalid !== 1'b0) begin
      fails++; $display("FAIL lw_b2b_issue got gnt=%b rvalid=%b want 1 0", ls_gnt, ls_rvalid);
    end
    step();
    ls_req = 1'b0;
    tests++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hAB000000) begin
      fails++; $display("FAIL lw_after_sb got v=%b d=%h want 1 ab000000", ls_rvalid, ls_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_mode = 2'b10; ls_addr = 32'h20;
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++; if (if_gnt !== (c % 5 == 4) || ls_gnt !== (c % 5 != 4) || dut.starve_cnt !== 3'(c % 5)) begin
        fails++; $display("FAIL starve[%0d] got if=%b ls=%b cnt=%0d want if=%b cnt=%0d", c, if_gnt, ls_gnt, dut.starve_cnt, c % 5 == 4, c % 5);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_misalign();
    logic [1:0] modes [3] = '{2'b10, 2'b10, 2'b11};
    logic       wes   [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      ls_req = 1'b1; ls_we = wes[i]; ls_mode = modes[i];
      ls_addr = (modes[i] == 2'b11) ? 32'h40 : 32'h42; ls_wdata = 32'hCAFEF00D;
      #1;
      tests++; if (ls_gnt !== 1'b1 || ram_we !== 1'b0) begin
        fails++; $display("FAIL bad_issue[%0d] got gnt=%b we=%b want 1 0", i, ls_gnt, ram_we);
      end
      step();
      ls_req = 1'b0; ls_we = 1'b0;
      tests++; if (ls_err !== 1'b1 || ls_rvalid !== 1'b0) begin
        fails++; $display("FAIL bad_err[%0d] got err=%b rvalid=%b want 1 0", i, ls_err, ls_rvalid);
      end
      step();
      tests++; if (ls_err !== 1'b0 || mem[16] !== 32'h11223344) begin
        fails++; $display("FAIL bad_after[%0d] got err=%b mem=%h want 0 11223344", i, ls_err, mem[16]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_addr = 32'h20; ls_mode = 2'b10;
    step(); step();
    ls_req = 1'b0;
    #1;
    tests++; if (if_gnt !== 1'b1 || dut.starve_cnt !== 3'd2) begin
      fails++; $display("FAIL mid_pre got gnt=%b cnt=%0d want 1 2", if_gnt, dut.starve_cnt);
    end
    #1 rstn = 1'b0;
    #1 if_req = 1'b0;
    step();
    tests++; if (if_rvalid !== 1'b0 || dut.starve_cnt !== 3'd0) begin
      fails++; $display("FAIL mid_reset got rvalid=%b cnt=%0d want 0 0", if_rvalid, dut.starve_cnt);
    end
    #2 rstn = 1'b1;
    step();
    tests++; if (if_rvalid !== 1'b0) begin fails++; $display("FAIL mid_dropped got rvalid=%b want 0", if_rvalid); end
    if_req = 1'b1; if_addr = 32'h20;
    step();
    if_req = 1'b0;
    tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h8086F00D) begin
      fails++; $display("FAIL mid_after got v=%b d=%h want 1 8086f00d", if_rvalid, if_rdata);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'h8086F00D;
    mem[16] = 32'h11223344;
    test_reset();
    test_if_read();
    test_ls_loads();
    test_back_to_back();
    test_starvation();
    test_misalign();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, synchronous-read data RAM between two requesters.
- Requesters are instruction fetch (IF, word reads only) and load/store unit (LS, byte/halfword/word reads and writes).
- Arbitrates each cycle, drives the RAM's write-enable/mode/addr/wdata port, and tracks the one-cycle read latency.
- Steers returned data to the owning requester; LS loads are extracted and extended. Misaligned or illegal LS accesses are blocked before reaching the RAM.

Parameters:
STARVE_MAX, 4, consecutive cycles IF may request without a grant before IF gets forced priority for one grant
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset, asynchronous, active-low
if_req  in  1  IF read request, held until if_gnt
if_addr  in  ADDR_W  IF byte address, word-aligned expected
if_gnt  out  1  IF request accepted this cycle (combinational)
if_rvalid  out  1  IF read data valid (registered flag)
if_rdata  out  32  IF read data
ls_req  in  1  LS request, held until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_mode  in  2  00 byte, 01 halfword, 10 word, 11 illegal
ls_unsigned  in  1  load zero-extends when 1, sign-extends when 0
ls_addr  in  ADDR_W  LS byte address
ls_wdata  in  32  store data, right-justified
ls_gnt  out  1  LS request accepted this cycle (combinational)
ls_rvalid  out  1  LS load data valid (registered flag)
ls_rdata  out  32  extracted/extended load data
ls_err  out  1  one-cycle pulse: previous granted LS access was misaligned/illegal
ram_we  out  1  RAM write enable
ram_mode  out  2  RAM access size
ram_addr  out  32  RAM byte address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after the read was issued

Behaviour:
- Reset (rstn low, async): if_rvalid=0, ls_rvalid=0, ls_err=0, starvation counter=0, pending-owner/offset/mode/unsigned regs=0.
- A read pending at reset is dropped; no rvalid follows.
- Combinational outputs (gnt, ram_*) are a function of inputs and the starvation counter.
- Arbitration, evaluated every cycle:
  - LS wins when ls_req=1, unless starve_cnt==STARVE_MAX and if_req=1, in which case IF wins.
  - Only one grant per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Alignment check (bad access):
  - Bad when ls_mode==11, or halfword with addr[0]=1, or word with addr[1:0]!=00.
  - A bad LS access is still granted (ls_gnt=1), but ram_we=0 and it counts as a no-op issue.
  - ls_err=1 the next cycle; ls_rvalid stays 0 for it.
- Issue-cycle RAM drive:
  - IF granted: ram_we=0, ram_mode=10, ram_addr=if_addr.
  - LS granted (good access): ram_we=ls_we, ram_mode=ls_mode, ram_addr=ls_addr, ram_wdata=ls_wdata.
  - No grant: ram_we=0, ram_mode=10, ram_addr=0, ram_wdata=0.
- Read latency:
  - Read granted in cycle N: the owner's rvalid=1 in cycle N+1 only; rdata is formed from ram_rdata that cycle.
  - A new grant may issue in cycle N+1, giving full back-to-back throughput of 1 access/cycle.
- Stores: complete at grant; no rvalid.
- IF data: if_rdata = ram_rdata.
- LS extraction uses the registered offset addr[1:0], mode and unsigned from the issue cycle:
  - byte: lane = ram_rdata[8*off+7:8*off], bits 31:8 = sign bit (lane[7]) or 0.
  - halfword: lane = ram_rdata[16*off[1]+15:16*off[1]], extended likewise from bit 15.
  - word: ram_rdata unchanged.
- rdata outside the rvalid cycle: if_rdata and ls_rdata are don't-care; the bench checks them only with rvalid=1.
- Simultaneous requests: the loser holds its request; its counter and priority evolve as above.
- IF address is not checked; it is passed through.

Test Plan:
- Single IF read: preload RAM word @0x10 = 0xDEADBEEF, if_req addr 0x10 -> if_gnt cycle N, if_rvalid N+1 only, if_rdata=0xDEADBEEF.
- LS byte loads from word 0x8086F00D at 0x20:
  - offset 1, signed -> ls_rdata=0xFFFFFFF0.
  - offset 1, unsigned -> 0x000000F0.
  - halfword offset 2, signed -> 0xFFFF8086.
- Store then load: sb 0xAB to 0x33, then lw 0x30 (RAM previously 0) -> ram_we=1, ram_mode=00 on the store cycle; the later load returns 0xAB000000; back-to-back grants with no gap.
- Contention/starvation: if_req and ls_req held high continuously -> LS granted 4 consecutive cycles, IF granted on the 5th, then the pattern repeats; the counter is observed to clear after the IF grant.
- Misalignment:
  - lw at 0x42 -> ls_gnt=1, ram_we=0, ls_err pulse next cycle, no ls_rvalid, RAM unchanged.
  - ls_mode=11 -> same result.
- Reset mid-read: issue an IF read, assert rstn low before the next edge -> if_rvalid stays 0, counter=0; after release, a normal read works.
